alu_exec_unit: RTL and testbench

//  Execute-stage ALU datapath; consumes the 4-bit Operation code from the ALU controller.

---
 rtl/alu_exec_unit.sv | 189 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. Logic, arithmetic and compare operations finish in one
// cycle. Shifts run on an iterative shifter that moves at most SHIFT_STEP bit
// positions per cycle. Operands arrive and results leave through valid/ready
// handshakes. Only one operation is in flight at a time.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : Operation/SrcA/SrcB are valid
//   in_ready   : unit can accept an operation (high only in IDLE)
//   Operation  : 4-bit operation select
//   SrcA       : operand A
//   SrcB       : operand B (shift amount lives in its low bits)
//   out_valid  : ALUResult/Zero are valid
//   out_ready  : consumer accepts the result
//   ALUResult  : registered result
//   Zero       : registered flag (A==B for EQ, otherwise ALUResult==0)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam int SW = $clog2(DATA_WIDTH);

    // Wide enough to hold SHIFT_STEP even when it equals DATA_WIDTH.
    localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    // Shift kind is the low two opcode bits: 00 SLL, 01 SRL, 11 SRA.
    localparam logic [1:0] KIND_SLL = 2'b00;
    localparam logic [1:0] KIND_SRL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;   // doubles as the shift working register
    logic                    zero_q,   zero_d;
    logic [SW-1:0]           count_q,  count_d;
    logic [1:0]              kind_q,   kind_d;

    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_zero;
    logic                    is_shift;
    logic [SW-1:0]           shamt;
    logic [SW-1:0]           step_k;
    logic [SW-1:0]           remaining;
    logic [DATA_WIDTH-1:0]   shifted;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            count_q  <= '0;
            kind_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            count_q  <= count_d;
            kind_q   <= kind_d;
        end
    end

    // ---------------------------------------------------------------------
    // Single-cycle operations
    // ---------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        unique case (Operation)
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_EQ:   alu_res = SrcA - SrcB;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_res = '0;
        endcase
        alu_zero = (Operation == OP_EQ) ? (SrcA == SrcB) : (alu_res == '0);
        is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
        shamt    = SrcB[SW-1:0];
    end

    // ---------------------------------------------------------------------
    // One iteration of the shifter
    // ---------------------------------------------------------------------
    always_comb begin
        // Take a full step unless fewer positions remain.
        step_k    = ({1'b0, count_q} >= STEP_W) ? STEP_W[SW-1:0] : count_q;
        remaining = count_q - step_k;
        unique case (kind_q)
            KIND_SLL: shifted = result_q << step_k;
            KIND_SRL: shifted = result_q >> step_k;
            // The working MSB is still the captured SrcA MSB, so an
            // arithmetic shift fills with the original sign.
            default:  shifted = $signed(result_q) >>> step_k;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath update
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        count_d  = count_q;
        kind_d   = kind_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d  = ST_SHIFT;
                        result_d = SrcA;
                        count_d  = shamt;
                        kind_d   = Operation[1:0];
                    end else if (is_shift) begin
                        state_d  = ST_DONE;
                        result_d = SrcA;
                        zero_d   = (SrcA == '0);
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = alu_zero;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = shifted;
                count_d  = remaining;
                if (remaining == '0) begin
                    state_d = ST_DONE;
                    zero_d  = (shifted == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        ALUResult = result_q;
        Zero      = zero_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_ready;

    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] alu_res;
    logic        zero;

    logic        in_valid8;
    logic        in_ready8;
    logic        out_valid8;
    logic [31:0] alu_res8;
    logic        zero8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (alu_res),
        .Zero      (zero)
    );

    alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .ALUResult (alu_res8),
        .Zero      (zero8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op to the selected instance and wait (bounded) for its result.
    // Latency counts cycles from the accept edge to the first out_valid sample.
    task automatic run(input bit sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output logic [31:0] res, output logic z);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        out_ready = 1'b1;
        if (sel) in_valid8 = 1'b1;
        else     in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        lat = 1;
        while (!(sel ? out_valid8 : out_valid) && lat < 100) begin
            tick();
            lat++;
        end
        res = sel ? alu_res8 : alu_res;
        z   = sel ? zero8 : zero;
        $display("op=%b A=0x%08h B=0x%08h step=%0d -> res=0x%08h zero=%0b lat=%0d",
                 op, a, b, sel ? 8 : 1, res, z, lat);
        tick();   // out_ready=1, so this edge completes the handshake
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        z;
        bit          seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        out_ready = 1'b0;
        Operation = 4'b0000;
        SrcA      = '0;
        SrcB      = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    alu_res,            32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd0);

        run(1'b0, 4'b0010, 32'd5, 32'd7, lat, res, z);
        chk("add_lat", lat, 32'd1);
        chk("add_res", res, 32'd12);
        chk("add_zero", {31'd0, z}, 32'd0);
        chk("add_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("add_out_valid_after", {31'd0, out_valid}, 32'd0);

        run(1'b0, 4'b0110, 32'd3, 32'd5, lat, res, z);
        chk("sub_res", res, 32'hFFFF_FFFE);
        chk("sub_zero", {31'd0, z}, 32'd0);

        run(1'b0, 4'b1000, 32'h1234, 32'h1234, lat, res, z);
        chk("eq_res", res, 32'd0);
        chk("eq_zero", {31'd0, z}, 32'd1);

        run(1'b0, 4'b1000, 32'h1234, 32'h1235, lat, res, z);
        chk("neq_zero", {31'd0, z}, 32'd0);

        run(1'b0, 4'b1100, 32'hFFFF_FFFF, 32'd1, lat, res, z);
        chk("slt_res", res, 32'd1);

        run(1'b0, 4'b1100, 32'd5, 32'hFFFF_FFFD, lat, res, z);
        chk("slt_ge_res", res, 32'd0);
        chk("slt_ge_zero", {31'd0, z}, 32'd1);

        run(1'b0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, res, z);
        chk("and_res", res, 32'h00F0_1234);
        run(1'b0, 4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, res, z);
        chk("or_res", res, 32'hFFF0_FFFF);
        run(1'b0, 4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, res, z);
        chk("xor_res", res, 32'hFF00_EDCB);

        run(1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, lat, res, z);
        chk("add_wrap_res", res, 32'd0);
        chk("add_wrap_zero", {31'd0, z}, 32'd1);

        run(1'b0, 4'b1001, 32'h5555_5555, 32'h1, lat, res, z);
        chk("illegal_lat", lat, 32'd1);
        chk("illegal_res", res, 32'd0);
        chk("illegal_zero", {31'd0, z}, 32'd1);

        run(1'b0, 4'b0111, 32'h8000_0000, 32'd4, lat, res, z);
        chk("sra_lat", lat, 32'd5);
        chk("sra_res", res, 32'hF800_0000);
        chk("sra_zero", {31'd0, z}, 32'd0);

        // Only the low five bits of SrcB form the shift amount: 32 means no shift.
        run(1'b0, 4'b0100, 32'hDEAD_BEEF, 32'd32, lat, res, z);
        chk("sll0_lat", lat, 32'd1);
        chk("sll0_res", res, 32'hDEAD_BEEF);

        run(1'b0, 4'b0100, 32'd1, 32'd3, lat, res, z);
        chk("sll3_lat", lat, 32'd4);
        chk("sll3_res", res, 32'd8);

        run(1'b0, 4'b0101, 32'h8000_0000, 32'd31, lat, res, z);
        chk("srl31_lat", lat, 32'd32);
        chk("srl31_res", res, 32'd1);

        run(1'b0, 4'b0100, 32'h8000_0001, 32'd1, lat, res, z);
        chk("sll_to_2_res", res, 32'd2);
        run(1'b0, 4'b0101, 32'd1, 32'd1, lat, res, z);
        chk("srl_to0_zero", {31'd0, z}, 32'd1);

        // SHIFT_STEP=8 instance
        run(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd31, lat, res, z);
        chk("s8_srl31_lat", lat, 32'd5);
        chk("s8_srl31_res", res, 32'd1);

        run(1'b1, 4'b0100, 32'd1, 32'd9, lat, res, z);
        chk("s8_sll9_lat", lat, 32'd3);
        chk("s8_sll9_res", res, 32'h0000_0200);

        run(1'b1, 4'b0111, 32'h8000_0000, 32'd8, lat, res, z);
        chk("s8_sra8_lat", lat, 32'd2);
        chk("s8_sra8_res", res, 32'hFF80_0000);

        // Back-pressure: result held while out_ready=0, new input ignored.
        Operation = 4'b0010;
        SrcA      = 32'h10;
        SrcB      = 32'h20;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        Operation = 4'b0110;
        SrcA      = 32'd0;
        SrcB      = 32'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result",    alu_res,            32'h30);
            chk("bp_zero",      {31'd0, zero},      32'd0);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            tick();
        end
        $display("backpressure hold: res=0x%08h zero=%0b", alu_res, zero);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("bp_ignored_no_result", {31'd0, out_valid}, 32'd0);

        // Reset two cycles into a 20-position shift aborts it.
        Operation = 4'b0100;
        SrcA      = 32'd1;
        SrcB      = 32'd20;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result",    alu_res,            32'd0);
        chk("abort_zero",      {31'd0, zero},      32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("abort_no_result", {31'd0, seen}, 32'd0);
        $display("mid-shift reset: aborted, out_valid seen=%0b", seen);

        run(1'b0, 4'b0010, 32'd2, 32'd3, lat, res, z);
        chk("post_abort_lat", lat, 32'd1);
        chk("post_abort_res", res, 32'd5);

        // Reset coincident with in_valid: the op must not be accepted.
        Operation = 4'b0010;
        SrcA      = 32'd1;
        SrcB      = 32'd1;
        reset     = 1'b1;
        in_valid  = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rst_vs_valid_no_result", {31'd0, out_valid}, 32'd0);
        $display("reset with in_valid: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        run(1'b0, 4'b0111, 32'h4000_0000, 32'd2, lat, res, z);
        chk("sra_pos_lat", lat, 32'd3);
        chk("sra_pos_res", res, 32'h1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
